// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and field-width helpers for the data cache
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_e;

  localparam int OFFSET_W    = 2;
  localparam int BLOCK_WORDS = 4;

  function automatic int index_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_width(input int add_w, input int num_lines);
    return add_w - $clog2(num_lines) - OFFSET_W;
  endfunction

endpackage

// File: rtl/cache_if.sv
// rtl/cache_if.sv - CPU data port and main-memory port bundle (slave = controller side)
interface cache_if #(
  parameter int ADD_WIDTH  = 10,
  parameter int DATA_WIDTH = 32
) ();

  logic                    cpu_read;
  logic                    cpu_write;
  logic [ADD_WIDTH-1:0]    cpu_add;
  logic [DATA_WIDTH-1:0]   cpu_write_data;
  logic [DATA_WIDTH-1:0]   cpu_read_data;
  logic                    stall;
  logic                    mem_read;
  logic                    mem_write;
  logic [ADD_WIDTH-1:0]    mem_add;
  logic [DATA_WIDTH-1:0]   mem_write_data;
  logic [4*DATA_WIDTH-1:0] mem_read_data;
  logic                    ready_to_read;
  logic                    finished_writing;

  modport slave (
    input  cpu_read, cpu_write, cpu_add, cpu_write_data,
    input  mem_read_data, ready_to_read, finished_writing,
    output cpu_read_data, stall,
    output mem_read, mem_write, mem_add, mem_write_data
  );

  modport master (
    output cpu_read, cpu_write, cpu_add, cpu_write_data,
    output mem_read_data, ready_to_read, finished_writing,
    input  cpu_read_data, stall,
    input  mem_read, mem_write, mem_add, mem_write_data
  );

endinterface

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - tag/valid/data arrays: one combinational read port, line fill, word write
module cache_line_store
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 32,
  parameter int TAG_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(NUM_LINES)-1:0]  index_i,
  input  logic [OFFSET_W-1:0]           offset_i,
  input  logic [TAG_W-1:0]              tag_i,
  input  logic                          fill_en_i,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] fill_block_i,
  input  logic                          word_en_i,
  input  logic [DATA_WIDTH-1:0]         word_data_i,
  output logic                          valid_o,
  output logic [TAG_W-1:0]              tag_o,
  output logic [DATA_WIDTH-1:0]         word_o
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES][BLOCK_WORDS];

  assign valid_o = valid_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign word_o  = data_q[index_i][offset_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[index_i] <= 1'b1;
      tag_q[index_i]   <= tag_i;
    end
  end

  // Data needs no reset: an invalid line is never reported as a hit.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      for (int w = 0; w < BLOCK_WORDS; w++) begin
        data_q[index_i][w] <= fill_block_i[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (word_en_i) begin
      data_q[index_i][offset_i] <= word_data_i;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-through no-allocate data cache; CACHE_STATS_EN adds hit/miss counters
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADD_WIDTH  = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 32
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  cache_if.slave      bus
);

  localparam int INDEX_W = index_width(NUM_LINES);
  localparam int TAG_W   = tag_width(ADD_WIDTH, NUM_LINES);

  state_e                state_q;
  logic                  first_q;
  logic [ADD_WIDTH-1:0]  mem_add_q;
  logic [DATA_WIDTH-1:0] mem_write_data_q;

  logic [ADD_WIDTH-1:0]  lookup_add;
  logic [INDEX_W-1:0]    lookup_index;
  logic [TAG_W-1:0]      lookup_tag;
  logic [OFFSET_W-1:0]   lookup_offset;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [DATA_WIDTH-1:0] line_word;
  logic                  hit;
  logic                  fill_done;
  logic                  write_done;

  // Outside IDLE the latched memory address selects the line, so the CPU bus is not trusted.
  assign lookup_add    = (state_q == IDLE) ? bus.cpu_add : mem_add_q;
  assign lookup_index  = lookup_add[OFFSET_W +: INDEX_W];
  assign lookup_tag    = lookup_add[ADD_WIDTH-1 -: TAG_W];
  assign lookup_offset = lookup_add[OFFSET_W-1:0];
  assign hit           = line_valid && (line_tag == lookup_tag);

  // The completion flag is ignored on the first cycle of a transfer: it may be left over.
  assign fill_done  = (state_q == FILL)  && !first_q && bus.ready_to_read;
  assign write_done = (state_q == WRITE) && !first_q && bus.finished_writing;

  cache_line_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .index_i     (lookup_index),
    .offset_i    (lookup_offset),
    .tag_i       (lookup_tag),
    .fill_en_i   (fill_done && !rst),
    .fill_block_i(bus.mem_read_data),
    .word_en_i   (write_done && hit && !rst),
    .word_data_i (mem_write_data_q),
    .valid_o     (line_valid),
    .tag_o       (line_tag),
    .word_o      (line_word)
  );

  always_comb begin
    bus.stall          = 1'b0;
    bus.cpu_read_data  = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_add        = mem_add_q;
    bus.mem_write_data = mem_write_data_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_write) begin
          bus.stall = 1'b1;
        end else if (bus.cpu_read) begin
          if (hit) bus.cpu_read_data = line_word;
          else     bus.stall         = 1'b1;
        end
      end
      FILL: begin
        bus.stall    = 1'b1;
        bus.mem_read = !fill_done;
      end
      WRITE: begin
        bus.stall     = !write_done;
        bus.mem_write = !write_done;
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      first_q          <= 1'b0;
      mem_add_q        <= '0;
      mem_write_data_q <= '0;
`ifdef CACHE_STATS_EN
      hit_count_q      <= '0;
      miss_count_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          first_q <= 1'b1;
          if (bus.cpu_write) begin
            state_q          <= WRITE;
            mem_add_q        <= bus.cpu_add;
            mem_write_data_q <= bus.cpu_write_data;
          end else if (bus.cpu_read && !hit) begin
            state_q   <= FILL;
            mem_add_q <= {bus.cpu_add[ADD_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
`ifdef CACHE_STATS_EN
            miss_count_q <= miss_count_q + 32'd1;
`endif
          end
`ifdef CACHE_STATS_EN
          else if (bus.cpu_read) begin
            hit_count_q <= hit_count_q + 32'd1;
          end
`endif
        end
        FILL: begin
          first_q <= 1'b0;
          if (fill_done) begin
            state_q   <= IDLE;
            mem_add_q <= '0;
          end
        end
        WRITE: begin
          first_q <= 1'b0;
          if (write_done) begin
            state_q          <= IDLE;
            mem_add_q        <= '0;
            mem_write_data_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed plus randomized checks of cache_controller against a line/memory model
module tb_cache_controller;
  import cache_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  cache_if #(.ADD_WIDTH(10), .DATA_WIDTH(32)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_controller #(.ADD_WIDTH(10), .DATA_WIDTH(32), .NUM_LINES(32)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CACHE_STATS_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: backing memory plus per-line valid/tag/data for a 32-line, 4-word-block cache.
  logic [31:0] mem_model [1024];
  bit          mv [32];
  int          mt [32];
  logic [31:0] md [32][4];

  function automatic int idx(input logic [9:0] a);
    return (int'(a) / 4) % 32;
  endfunction

  function automatic int tg(input logic [9:0] a);
    return int'(a) / 128;
  endfunction

  function automatic int off(input logic [9:0] a);
    return int'(a) % 4;
  endfunction

  function automatic logic [127:0] blk(input logic [9:0] a);
    int b;
    b = int'(a) - off(a);
    return {mem_model[b+3], mem_model[b+2], mem_model[b+1], mem_model[b]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [9:0] a, input int lat, input bit stale);
    int i;
    bit hit;
    i   = idx(a);
    hit = mv[i] && (mt[i] == tg(a));
    bus.cpu_read = 1'b1;
    bus.cpu_write = 1'b0;
    bus.cpu_add = a;
    if (stale) begin
      bus.ready_to_read = 1'b1;
      bus.mem_read_data = blk(a);
    end
    #1;
    if (hit) begin
      chk("rd_hit_stall", bus.stall, 0);
      chk("rd_hit_data", bus.cpu_read_data, md[i][off(a)]);
      tick();
      bus.cpu_read = 1'b0;
      bus.ready_to_read = 1'b0;
      return;
    end
    chk("rd_miss_stall", bus.stall, 1);
    chk("rd_miss_idle_mreq", bus.mem_read, 0);
    tick();
    chk("fill_first_mreq", bus.mem_read, 1);
    chk("fill_add", bus.mem_add, int'(a) - off(a));
    if (!stale) begin
      repeat (lat) begin
        tick();
        chk("fill_wait_mreq", bus.mem_read, 1);
        chk("fill_wait_stall", bus.stall, 1);
      end
      tick();
      bus.ready_to_read = 1'b1;
      bus.mem_read_data = blk(a);
      #1;
    end else begin
      tick();
    end
    chk("fill_done_mreq", bus.mem_read, 0);
    chk("fill_done_stall", bus.stall, 1);
    tick();
    bus.ready_to_read = 1'b0;
    #1;
    mv[i] = 1'b1;
    mt[i] = tg(a);
    for (int w = 0; w < 4; w++) md[i][w] = mem_model[int'(a) - off(a) + w];
    chk("rd_after_fill_stall", bus.stall, 0);
    chk("rd_after_fill_data", bus.cpu_read_data, md[i][off(a)]);
    tick();
    bus.cpu_read = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input int lat,
                          input bit stale, input bit also_read);
    int i;
    bit hit;
    i   = idx(a);
    hit = mv[i] && (mt[i] == tg(a));
    bus.cpu_write = 1'b1;
    bus.cpu_read = also_read;
    bus.cpu_add = a;
    bus.cpu_write_data = d;
    if (stale) bus.finished_writing = 1'b1;
    #1;
    chk("wr_req_stall", bus.stall, 1);
    chk("wr_req_rdata", bus.cpu_read_data, 0);
    chk("wr_req_mreq", bus.mem_write, 0);
    tick();
    chk("wr_first_mreq", bus.mem_write, 1);
    chk("wr_add", bus.mem_add, a);
    chk("wr_data", bus.mem_write_data, d);
    chk("wr_first_stall", bus.stall, 1);
    if (!stale) begin
      repeat (lat) begin
        tick();
        chk("wr_wait_mreq", bus.mem_write, 1);
      end
      tick();
      bus.finished_writing = 1'b1;
      #1;
    end else begin
      tick();
    end
    chk("wr_done_mreq", bus.mem_write, 0);
    chk("wr_done_stall", bus.stall, 0);
    mem_model[a] = d;
    if (hit) md[i][off(a)] = d;
    tick();
    bus.cpu_write = 1'b0;
    bus.cpu_read = 1'b0;
    bus.finished_writing = 1'b0;
    #1;
    chk("wr_idle_mreq", bus.mem_write, 0);
    chk("wr_idle_add", bus.mem_add, 0);
    chk("wr_idle_stall", bus.stall, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_add = '0;
    bus.cpu_write_data = '0;
    bus.mem_read_data = '0;
    bus.ready_to_read = 1'b0;
    bus.finished_writing = 1'b0;
    for (int k = 0; k < 1024; k++) mem_model[k] = $urandom;
    for (int k = 0; k < 32; k++) mv[k] = 1'b0;

    repeat (2) tick();
    chk("rst_stall", bus.stall, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_add", bus.mem_add, 0);
    chk("rst_mem_wdata", bus.mem_write_data, 0);
    chk("rst_rdata", bus.cpu_read_data, 0);
    rst = 1'b0;
    tick();

    do_read(10'h005, 2, 1'b0);
    do_read(10'h007, 0, 1'b0);
    do_write(10'h006, 32'hDEADBEEF, 2, 1'b0, 1'b0);
    do_read(10'h006, 0, 1'b0);
    chk("wt_hit_model", md[1][2], 32'hDEADBEEF);
    do_write(10'h3F0, 32'h12345678, 1, 1'b0, 1'b0);
    chk("wr_miss_noalloc", mv[idx(10'h3F0)], 0);
    do_read(10'h3F0, 0, 1'b0);
    do_read(10'h004, 0, 1'b0);
    do_read(10'h084, 1, 1'b0);
    do_read(10'h004, 0, 1'b0);
    do_read(10'h210, 0, 1'b1);
    do_write(10'h211, 32'hA5A5_0F0F, 0, 1'b1, 1'b1);
    do_read(10'h211, 0, 1'b0);

    bus.cpu_read = 1'b1;
    bus.cpu_add = 10'h2A8;
    #1;
    chk("rstfill_miss_stall", bus.stall, 1);
    tick();
    tick();
    chk("rstfill_mreq", bus.mem_read, 1);
    rst = 1'b1;
    bus.ready_to_read = 1'b1;
    bus.mem_read_data = blk(10'h2A8);
    tick();
    rst = 1'b0;
    bus.ready_to_read = 1'b0;
    bus.cpu_read = 1'b0;
    #1;
    chk("rstfill_stall", bus.stall, 0);
    chk("rstfill_mem_read", bus.mem_read, 0);
    chk("rstfill_mem_add", bus.mem_add, 0);
    for (int k = 0; k < 32; k++) mv[k] = 1'b0;
    do_read(10'h2A8, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [9:0] ra;
      ra = 10'(($urandom_range(0, 2) * 128) + ($urandom_range(0, 3) * 4) + $urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0)
        do_read(ra, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else
        do_write(ra, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
